// File: rtl/riscv_pc_seq.sv
// riscv_pc_seq: program-counter owner and fetch/execute sequencer for the non-pipelined core.
// Optional trap redirects are enabled by defining RISCV_PC_SEQ_TRAP_EN.
module riscv_pc_seq #(
    parameter int unsigned DLY_FF    = 1,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    output logic        imem_req,
    output logic [14:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_vld,
    input  logic        ex_done,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic [14:0] pc_out,
    output logic [14:0] pc_4,
    output logic [31:0] instret,
    output logic        fetch_err,
    output logic        trap
);

`ifdef RISCV_PC_SEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // DLY_FF only shapes simulation models; the RTL carries no delays.
    if (DLY_FF > 32'd255) begin : g_dly_ff_unused
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_instret;
    logic             r_instr_vld;
    logic             r_fetch_err;
    logic             r_trap;
    logic [CNT_W-1:0] r_to_cnt;

    logic             w_req;
    logic             w_ack;
    logic             w_to_hit;
    logic             w_trap_br;
    logic [31:0]      w_tgt;
    logic [31:0]      w_retire_pc;

    assign w_req    = (r_state == ST_FETCH) && !halt;
    assign w_ack    = w_req && imem_ack;
    // Terminal wait cycle; a coincident ack takes priority over the timeout.
    assign w_to_hit = w_req && !imem_ack && (r_to_cnt == CNT_LAST);

    assign w_trap_br   = TRAP_EN && ex_taken && (ex_target[1:0] != 2'b00);
    assign w_tgt       = TRAP_EN ? ex_target : (ex_target & ~32'h3);
    assign w_retire_pc = w_trap_br ? TRAP_VEC :
                         ex_taken  ? w_tgt    : (r_pc + 32'd4);

    // Sequencer state, PC, captured instruction and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_VEC;
            r_instr     <= 32'd0;
            r_instret   <= 32'd0;
            r_instr_vld <= 1'b0;
            r_fetch_err <= 1'b0;
            r_trap      <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_fetch_err <= 1'b0;
            r_trap      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_FETCH;
                    r_to_cnt <= '0;
                end
                ST_FETCH: begin
                    if (w_ack) begin
                        r_instr     <= imem_rdata;
                        r_instr_vld <= 1'b1;
                        r_state     <= ST_EXEC;
                    end else if (w_to_hit) begin
                        r_fetch_err <= 1'b1;
                        r_to_cnt    <= '0;
                        if (TRAP_EN) begin
                            r_pc   <= TRAP_VEC;
                            r_trap <= 1'b1;
                        end
                    end else if (w_req) begin
                        r_to_cnt <= r_to_cnt + CNT_W'(1);
                    end
                end
                ST_EXEC: begin
                    if (ex_done) begin
                        r_pc        <= w_retire_pc;
                        r_instret   <= r_instret + 32'd1;
                        r_trap      <= w_trap_br;
                        r_instr_vld <= 1'b0;
                        r_to_cnt    <= '0;
                        r_state     <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc[14:0];
    assign instr     = r_instr;
    assign instr_vld = r_instr_vld;
    assign pc_out    = r_pc[14:0];
    assign pc_4      = r_pc[14:0] + 15'd4;
    assign instret   = r_instret;
    assign fetch_err = r_fetch_err;
    assign trap      = TRAP_EN & r_trap;

endmodule

// File: doc/riscv_pc_seq.md
# riscv_pc_seq

Instruction-sequencing controller for the non-pipelined RISC-V core. It owns the program counter and runs the fetch/execute cycle: it issues instruction-memory requests, holds the fetched word for the execute stage, and advances the PC on retire by either +4 or a resolved branch/jump target. It also counts retired instructions and detects fetch timeouts.

## Interface
- DLY_FF, 1: flop update delay (simulation only)
- RESET_VEC, 32'h0000_0000: PC value after reset
- TRAP_VEC, 32'h0000_0100: redirect PC for traps (used only with the macro)
- TIMEOUT, 16: fetch-wait cycles before a fetch error (range 2..255)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- halt  in  1  hold in FETCH; no new request is issued
- imem_req  out  1  instruction fetch request
- imem_addr  out  15  fetch address, equal to pc[14:0]
- imem_ack  in  1  fetch data valid on imem_rdata
- imem_rdata  in  32  fetched instruction
- instr  out  32  captured instruction
- instr_vld  out  1  instr is valid for execute
- ex_done  in  1  execute stage has finished the current instruction
- ex_taken  in  1  branch/jump taken (qualified by ex_done)
- ex_target  in  32  taken target (qualified by ex_done and ex_taken)
- pc_out  out  15  current PC, pc[14:0]
- pc_4  out  15  pc[14:0] + 4, 15-bit wrap
- instret  out  32  retired-instruction count
- fetch_err  out  1  single-cycle pulse on fetch timeout
- trap  out  1  single-cycle pulse on trap redirect

## Operation
- State machine: IDLE -> FETCH -> EXEC -> FETCH …
- IDLE: entered only from reset and lasts one cycle.
- FETCH: imem_req = !halt, combinational from state. imem_addr is stable for the whole state.
  - imem_ack sampled high while imem_req is high: instr <= imem_rdata, go to EXEC.
  - imem_ack is ignored while imem_req is low (halt, or any other state).
- EXEC: instr_vld = 1. Wait for ex_done. On ex_done:
  - pc <= ex_taken ? ex_target : pc + 4 (32-bit internal, wrap modulo 2^32)
  - instret++ (wraps at 2^32 - 1 to 0)
  - go to FETCH
- Timeout counter (8-bit):
  - Cleared on entry to FETCH.
  - Counts each FETCH cycle with imem_req high and no ack. halt freezes it.
  - Reaching TIMEOUT-1 without an ack raises fetch_err for one cycle, then the fetch is resolved per Configuration.
- Simultaneous ack and timeout-terminal cycle: the ack wins and no fetch_err is raised.
- halt asserted in EXEC has no effect until the return to FETCH.
- Reset mid-operation: the state machine returns to IDLE immediately. Any in-flight ack is discarded.

## Timing
- Reset values:
  - pc = RESET_VEC, so pc_out = RESET_VEC[14:0] and pc_4 = that value + 4
  - instr = 0, instr_vld = 0, imem_req = 0, instret = 0, fetch_err = 0, trap = 0
- Cycle after reset deassert: IDLE. Next cycle: FETCH with imem_req high.
- Minimum instruction period is 2 cycles: ack in the first FETCH cycle, ex_done in the first EXEC cycle.
- instr, pc and instret update on the sampling edge. instr_vld rises the cycle after the ack.
- pc_out and pc_4 change the cycle after ex_done. Retire is visible at pc_out before the next imem_req.
- fetch_err and trap are registered: they are high for exactly one cycle, the cycle after the detecting edge.

## Configuration
- RISCV_PC_SEQ_TRAP_EN defined:
  - On ex_done with ex_taken and ex_target[1:0] != 0: pc <= TRAP_VEC, trap pulses, instret still increments.
  - On fetch timeout: pc <= TRAP_VEC, trap pulses together with fetch_err, and the state machine restarts FETCH at TRAP_VEC.
- Not defined:
  - ex_target[1:0] is forced to 00.
  - trap is tied 0.
  - On fetch timeout the same address is re-requested: the counter clears, imem_req stays high and fetch_err still pulses.

## Test plan
- Reset release, imem_ack returned one cycle after each request, ex_done one cycle after instr_vld, no branches -> imem_addr sequence 0x0000, 0x0004, 0x0008; instret = 3 after the third ex_done.
- ex_taken = 1, ex_target = 0x0000_0200 on the second retire -> next imem_addr = 0x0200 and pc_4 = 0x0204.
- halt held 5 cycles in FETCH with imem_ack high -> imem_req stays 0, the ack is ignored, instr is unchanged, and no fetch_err occurs.
- No ack for TIMEOUT = 16 request cycles:
  - With the macro: fetch_err and trap pulse once, and next imem_addr = 0x0100.
  - Without the macro: fetch_err pulses and imem_addr stays the same.
- ex_target = 0x0000_0202 taken:
  - With the macro: trap pulses and pc_out = 0x0100.
  - Without the macro: pc_out = 0x0200.
- Reset asserted in EXEC with ex_done high in the same cycle -> pc_out = 0, instret = 0, instr_vld = 0; the sequence restarts at 0x0000.
